fnd_scan_display: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment (FND) driver for the board display path.

---
 rtl/fnd_pkg.sv | 33 +++
 rtl/fnd_bin2bcd.sv | 71 +++++++
 rtl/fnd_scan_display.sv | 200 ++++++++++++++++++++
 tb/tb_fnd_scan_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and segment encoding for the multiplexed 7-segment display driver.
// Patterns are stored active-low as {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } fnd_state_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_DP    = 8'h80;

   function automatic logic [7:0] seg7(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, DATA_W cycles after start.
// done pulses during the final shift cycle; bcd is complete on the following cycle.
module fnd_bin2bcd
   import fnd_pkg::*;
#(
   parameter int DATA_W     = 14,
   parameter int BCD_DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_W-1:0]       bin,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0]       bin_q, bin_d;
   logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj_s;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    busy_q, busy_d;

   // Add-3 correction on every nibble, then shift the binary MSB into the BCD word
   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      adj_s  = bcd_q;
      done   = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            adj_s[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end else begin
            adj_s[i*4 +: 4] = bcd_q[i*4 +: 4];
         end
      end
      if (start) begin
         bin_d  = bin;
         bcd_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d  = {adj_s[4*BCD_DIGITS-2:0], bin_q[DATA_W-1]};
         bin_d  = {bin_q[DATA_W-2:0], 1'b0};
         cnt_d  = cnt_q + CNT_W'(1);
         busy_d = !done;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Conversion state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/fnd_scan_display.sv
// N-digit multiplexed FND driver: handshake-fed binary value, BCD conversion, scanned output.
// Optional blink of selected digits when FND_BLINK_EN is defined.
module fnd_scan_display
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_W     = 14,
   parameter int CLK_HZ     = 100_000_000,
   parameter int SCAN_HZ    = 1000,
   parameter int ACTIVE_LOW = 1
`ifdef FND_BLINK_EN
   ,parameter int BLINK_HZ  = 2
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic                  blank_lz,
`ifdef FND_BLINK_EN
   input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] fnd_digit,
   output logic [7:0]            fnd_data
);

   localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 1;
   localparam int TICK_DIV   = CLK_HZ / SCAN_HZ;
   localparam int DIV_W      = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam logic [7:0]            OFF_DATA  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] OFF_DIGIT = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   fnd_state_e                state_q, state_d;
   logic                      in_ready_q, in_ready_d;
   logic                      ovf_q, ovf_d;
   logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
   logic [DIV_W-1:0]          div_q, div_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NUM_DIGITS-1:0]     digit_q, digit_d, onehot_s;
   logic [7:0]                data_q, data_d, seg_s;
   logic                      conv_start_s, conv_done_s, tick_s, upper_zero_s, hide_s;
   logic [4*BCD_DIGITS-1:0]   conv_bcd_s;
   logic [4*(BCD_DIGITS+NUM_DIGITS)-1:0] bcd_ext_s;

   fnd_bin2bcd #(.DATA_W(DATA_W), .BCD_DIGITS(BCD_DIGITS)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start_s),
      .bin   (in_data),
      .done  (conv_done_s),
      .bcd   (conv_bcd_s)
   );

   // Zero-extend so digit slices beyond either width stay in range
   assign bcd_ext_s = {{(4*NUM_DIGITS){1'b0}}, conv_bcd_s};

   // Handshake FSM; display and overflow change together only in LOAD
   always_comb begin
      state_d      = state_q;
      disp_d       = disp_q;
      ovf_d        = ovf_q;
      conv_start_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               conv_start_s = 1'b1;
               state_d      = CONV;
            end else begin
               state_d      = IDLE;
            end
         end
         CONV: begin
            if (conv_done_s) begin
               state_d = LOAD;
            end else begin
               state_d = CONV;
            end
         end
         LOAD: begin
            ovf_d = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               disp_d[i*4 +: 4] = bcd_ext_s[i*4 +: 4];
            end
            for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
               ovf_d = ovf_d | (|bcd_ext_s[i*4 +: 4]);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   // Scan tick divider and digit index
   always_comb begin
      tick_s = (div_q == DIV_W'(TICK_DIV - 1));
      if (tick_s) begin
         div_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
         div_d = div_q + DIV_W'(1);
         idx_d = idx_q;
      end
   end

`ifdef FND_BLINK_EN
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int BDIV_W    = ($clog2(BLINK_DIV) > 0) ? $clog2(BLINK_DIV) : 1;
   logic [BDIV_W-1:0] bdiv_q, bdiv_d;
   logic              blink_on_q, blink_on_d;

   // Free-running blink phase, toggling every half-period
   always_comb begin
      if (bdiv_q == BDIV_W'(BLINK_DIV - 1)) begin
         bdiv_d     = '0;
         blink_on_d = !blink_on_q;
      end else begin
         bdiv_d     = bdiv_q + BDIV_W'(1);
         blink_on_d = blink_on_q;
      end
   end

   // Blink phase registers, starting in the "on" half
   always_ff @(posedge clk) begin
      if (rst) begin
         bdiv_q     <= '0;
         blink_on_q <= 1'b1;
      end else begin
         bdiv_q     <= bdiv_d;
         blink_on_q <= blink_on_d;
      end
   end
`endif

   // Segment pattern for the currently scanned digit
   always_comb begin
      upper_zero_s = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         upper_zero_s = upper_zero_s &
                        ~((IDX_W'(i) >= idx_q) && (disp_q[i*4 +: 4] != 4'd0));
      end
      hide_s = blank_lz && !ovf_q && (idx_q != '0) && upper_zero_s;
`ifdef FND_BLINK_EN
      hide_s = hide_s | (blink_mask[idx_q] & ~blink_on_q);
`endif
      if (hide_s) begin
         seg_s = SEG_BLANK;
      end else if (ovf_q) begin
         seg_s = SEG_DASH;
      end else begin
         seg_s = seg7(disp_q[idx_q*4 +: 4]);
      end
      if (dp_mask[idx_q]) begin
         seg_s = seg_s & ~SEG_DP;
      end else begin
         seg_s = seg_s;
      end
      onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
      if (ACTIVE_LOW != 0) begin
         data_d  = seg_s;
         digit_d = ~onehot_s;
      end else begin
         data_d  = ~seg_s;
         digit_d = onehot_s;
      end
   end

   // All state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b1;
         ovf_q      <= 1'b0;
         disp_q     <= '0;
         div_q      <= '0;
         idx_q      <= '0;
         digit_q    <= OFF_DIGIT;
         data_q     <= OFF_DATA;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         ovf_q      <= ovf_d;
         disp_q     <= disp_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
         digit_q    <= digit_d;
         data_q     <= data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign overflow  = ovf_q;
   assign fnd_digit = digit_q;
   assign fnd_data  = data_q;

endmodule

// File: tb/tb_fnd_scan_display.sv
// Directed self-checking bench for fnd_scan_display (4 digits, 14-bit data, tick every 10 cycles).
module tb_fnd_scan_display;

   logic       clk = 1'b0;
   logic       rst;
   logic [13:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] dp_mask;
   logic       blank_lz;
   logic       overflow;
   logic [3:0] fnd_digit;
   logic [7:0] fnd_data;

   int checks = 0;
   int errors = 0;
   int cyc;
   int n;

   always #5 clk = ~clk;

   fnd_scan_display #(
      .NUM_DIGITS (4),
      .DATA_W     (14),
      .CLK_HZ     (1000),
      .SCAN_HZ    (100),
      .ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dp_mask   (dp_mask),
      .blank_lz  (blank_lz),
`ifdef FND_BLINK_EN
      .blink_mask(4'b0000),
`endif
      .overflow  (overflow),
      .fnd_digit (fnd_digit),
      .fnd_data  (fnd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_digit(input logic [3:0] pat, input string tag);
      int k;
      k = 0;
      @(posedge clk);
      @(negedge clk);
      while (fnd_digit !== pat && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k >= 60) chk({tag, "_timeout"}, 32'(fnd_digit), 32'(pat));
   endtask

   task automatic rd(input logic [3:0] pat, input logic [7:0] exp, input string tag);
      wait_digit(pat, tag);
      chk(tag, 32'(fnd_data), 32'(exp));
   endtask

   task automatic send(input logic [13:0] val);
      @(negedge clk);
      in_data  = val;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_ready();
      while (!in_ready && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
      end
   endtask

   task automatic load(input logic [13:0] val, input string tag);
      send(val);
      wait_ready();
      chk({tag, "_accept_to_ready"}, 32'(cyc), 32'd16);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 14'd0; dp_mask = 4'b0000; blank_lz = 1'b0;

      // 1. reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_digit", 32'(fnd_digit), 32'h0000000F);
      chk("rst_data", 32'(fnd_data), 32'h000000FF);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;

      // 2. 1234 without blanking, plus scan period
      load(14'd1234, "v1234");
      chk("v1234_ovf", 32'(overflow), 32'd0);
      rd(4'b1110, 8'h99, "v1234_d0");
      rd(4'b1101, 8'hB0, "v1234_d1");
      rd(4'b1011, 8'hA4, "v1234_d2");
      rd(4'b0111, 8'hF9, "v1234_d3");
      wait_digit(4'b1110, "period");
      n = 0;
      while (fnd_digit === 4'b1110 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("scan_period", 32'(n), 32'd10);
      chk("scan_next", 32'(fnd_digit), 32'h0000000D);

      // 3. leading-zero blanking
      blank_lz = 1'b1;
      load(14'd7, "v7");
      rd(4'b1110, 8'hF8, "v7_lz_d0");
      rd(4'b1101, 8'hFF, "v7_lz_d1");
      rd(4'b0111, 8'hFF, "v7_lz_d3");
      blank_lz = 1'b0;
      rd(4'b1101, 8'hC0, "v7_nolz_d1");
      rd(4'b1011, 8'hC0, "v7_nolz_d2");
      blank_lz = 1'b1;
      load(14'd0, "v0");
      rd(4'b1110, 8'hC0, "v0_lz_d0");
      rd(4'b1101, 8'hFF, "v0_lz_d1");
      load(14'd102, "v102");
      rd(4'b1101, 8'hC0, "v102_lz_inner0");
      rd(4'b1011, 8'hF9, "v102_lz_d2");
      rd(4'b0111, 8'hFF, "v102_lz_d3");
      blank_lz = 1'b0;

      // 4. overflow boundary
      load(14'd10000, "v10000");
      chk("v10000_ovf", 32'(overflow), 32'd1);
      rd(4'b1110, 8'hBF, "v10000_d0");
      rd(4'b0111, 8'hBF, "v10000_d3");
      load(14'd9999, "v9999");
      chk("v9999_ovf", 32'(overflow), 32'd0);
      rd(4'b1110, 8'h90, "v9999_d0");
      rd(4'b0111, 8'h90, "v9999_d3");

      // 5. in_valid during conversion is ignored; decimal point
      send(14'd1234);
      repeat (3) begin
         @(posedge clk);
         #1 cyc++;
      end
      in_data  = 14'd4321;
      in_valid = 1'b1;
      @(posedge clk);
      #1 cyc++;
      in_valid = 1'b0;
      wait_ready();
      chk("busy_accept_to_ready", 32'(cyc), 32'd16);
      repeat (3) @(posedge clk);
      #1 chk("busy_no_requeue", 32'(in_ready), 32'd1);
      dp_mask = 4'b0100;
      rd(4'b1110, 8'h99, "busy_d0");
      rd(4'b1011, 8'h24, "dp_d2");
      rd(4'b0111, 8'hF9, "busy_d3");
      dp_mask = 4'b0000;

      // 6. reset in the middle of a conversion
      send(14'd4321);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_digit", 32'(fnd_digit), 32'h0000000F);
      chk("mid_rst_data", 32'(fnd_data), 32'h000000FF);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("no_stale_ready", 32'(in_ready), 32'd1);
      rd(4'b1110, 8'hC0, "no_stale_d0");
      rd(4'b0111, 8'hC0, "no_stale_d3");
      load(14'd56, "v56");
      rd(4'b1110, 8'h82, "v56_d0");
      rd(4'b1101, 8'h92, "v56_d1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
